modport_slave: RTL and testbench

MODPORT_SLAVE -- requirements
Module: modport_slave

---
 rtl/modport_slave_pkg.sv | 26 ++
 rtl/modport_slave_mem.sv | 42 ++++
 rtl/modport_slave.sv | 208 ++++++++++++++++++++
 tb/tb_modport_slave.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/modport_slave_pkg.sv
// -----------------------------------------------------------------------------
// modport_slave_pkg
// Shared definitions for the APB memory slave: the transfer state encoding,
// default bus/storage dimensions and the wait-counter width.
// -----------------------------------------------------------------------------
package modport_slave_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 8;
  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_MEM_DEPTH   = 64;
  localparam int unsigned MAX_WAIT_STATES = 7;
  // Wide enough to hold MAX_WAIT_STATES.
  localparam int unsigned WAIT_CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // True when a word index addresses an implemented storage word.
  function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned depth);
    return (idx < depth);
  endfunction

endpackage

// File: rtl/modport_slave_mem.sv
// -----------------------------------------------------------------------------
// modport_slave_mem
// Word storage for the APB slave: one synchronous write port, one
// combinational read port, whole array cleared by the asynchronous reset.
// Ports:
//   clk_i    clock (rising edge)
//   rst_i    asynchronous active-high clear of every word
//   we_i     write enable, waddr_i/wdata_i captured on the rising edge
//   raddr_i  combinational read address, rdata_o the addressed word
// The caller only presents in-range indices.
// -----------------------------------------------------------------------------
module modport_slave_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned IDX_W      = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // Storage array: async clear, synchronous write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read port.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/modport_slave.sv
// -----------------------------------------------------------------------------
// modport_slave
// APB slave fronting a small word memory. A transfer walks IDLE -> SETUP ->
// ACCESS; address, direction and write data are captured when leaving SETUP.
// ACCESS holds PREADY low for WAIT_STATES cycles, then completes for one
// cycle. Word indices at or beyond MEM_DEPTH complete with PSLVERR and no
// storage side effect. All outputs are registered.
// Ports:
//   PCLK              clock (rising edge)
//   PRESETn           asynchronous reset, ACTIVE-HIGH despite the name
//   PSELx/PENABLE     APB select / access-phase indicator
//   PWRITE            1 = write, 0 = read
//   PADDR/PWDATA      byte address / write data
//   PRDATA            read data, non-zero only while completing a good read
//   PREADY/PSLVERR    completion / error (error only alongside PREADY)
// -----------------------------------------------------------------------------
module modport_slave
  import modport_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int unsigned IDX_W     = ADDR_WIDTH - 2;
  localparam int unsigned MEM_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  apb_state_e            state_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic                  write_q;
  logic                  err_q;
  logic [MEM_IDX_W-1:0]  idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;

  logic [IDX_W-1:0]      live_idx_s;
  logic                  live_err_s;
  logic [MEM_IDX_W-1:0]  mem_raddr_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic                  mem_we_s;
  logic [DATA_WIDTH-1:0] rdata_setup_d;
  logic [DATA_WIDTH-1:0] rdata_access_d;
  logic                  unused_addr_lsb_s;

  // Byte-lane bits do not take part in word addressing.
  assign unused_addr_lsb_s = ^PADDR[1:0];

  // Address decode, read-port steering and completion read data.
  always_comb begin
    live_idx_s = PADDR[ADDR_WIDTH-1:2];
    live_err_s = !idx_in_range(32'(live_idx_s), MEM_DEPTH);

    // While in SETUP the transfer is not latched yet, so read from the live
    // address; this lets a zero-wait read present data in its first ACCESS cycle.
    if (state_q == SETUP) begin
      mem_raddr_s = MEM_IDX_W'(live_idx_s);
    end else begin
      mem_raddr_s = idx_q;
    end

    if (!PWRITE && !live_err_s) begin
      rdata_setup_d = mem_rdata_s;
    end else begin
      rdata_setup_d = '0;
    end

    if (!write_q && !err_q) begin
      rdata_access_d = mem_rdata_s;
    end else begin
      rdata_access_d = '0;
    end

    // Storage only changes on the completing edge of a good write.
    mem_we_s = (state_q == ACCESS) && pready_q && write_q && !err_q;
  end

  // Transfer FSM with wait counter and registered APB responses.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          prdata_q   <= '0;
          pready_q   <= 1'b0;
          pslverr_q  <= 1'b0;
          if (PSELx && !PENABLE) begin
            state_q <= SETUP;
          end else begin
            state_q <= IDLE;
          end
        end

        SETUP: begin
          if (!PSELx) begin
            // Master withdrew before the access phase: drop the transfer.
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
          end else begin
            state_q    <= ACCESS;
            write_q    <= PWRITE;
            err_q      <= live_err_s;
            idx_q      <= MEM_IDX_W'(live_idx_s);
            wdata_q    <= PWDATA;
            wait_cnt_q <= WAIT_CNT_W'(WAIT_STATES);
            if (WAIT_STATES == 32'd0) begin
              pready_q  <= 1'b1;
              pslverr_q <= live_err_s;
              prdata_q  <= rdata_setup_d;
            end else begin
              pready_q  <= 1'b0;
              pslverr_q <= 1'b0;
              prdata_q  <= '0;
            end
          end
        end

        ACCESS: begin
          if (pready_q) begin
            // Completing cycle; a fresh SETUP request chains directly.
            wait_cnt_q <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            if (PSELx && !PENABLE) begin
              state_q <= SETUP;
            end else begin
              state_q <= IDLE;
            end
          end else if (!PSELx) begin
            // Abort during wait states: no completion, no write.
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
          end else begin
            state_q    <= ACCESS;
            wait_cnt_q <= wait_cnt_q - WAIT_CNT_W'(1);
            // PREADY rises exactly as the counter reaches zero.
            if (wait_cnt_q == WAIT_CNT_W'(1)) begin
              pready_q  <= 1'b1;
              pslverr_q <= err_q;
              prdata_q  <= rdata_access_d;
            end else begin
              pready_q  <= 1'b0;
              pslverr_q <= 1'b0;
              prdata_q  <= '0;
            end
          end
        end

        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= '0;
          prdata_q   <= '0;
          pready_q   <= 1'b0;
          pslverr_q  <= 1'b0;
        end
      endcase
    end
  end

  modport_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (MEM_IDX_W)
  ) u_mem (
    .clk_i   (PCLK),
    .rst_i   (PRESETn),
    .we_i    (mem_we_s),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (mem_raddr_s),
    .rdata_o (mem_rdata_s)
  );

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_modport_slave.sv
// -----------------------------------------------------------------------------
// tb_modport_slave
// Two slaves share clock and reset: dut 0 has no wait states, dut 1 has three.
// A 10-bit address bus lets the out-of-range word 0x100 be addressed.
// The driver pushes the expected completion into a per-dut queue; a negedge
// monitor pops and compares whenever PREADY is seen high, and otherwise
// requires PRDATA and PSLVERR to be zero.
// -----------------------------------------------------------------------------
module tb_modport_slave;

  localparam int AW = 10;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]         psel;
  logic [1:0]         penable;
  logic [1:0]         pwrite;
  logic [1:0][AW-1:0] paddr;
  logic [1:0][31:0]   pwdata;
  logic [1:0][31:0]   prdata;
  logic [1:0]         pready;
  logic [1:0]         pslverr;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modport_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESETn(rst), .PSELx(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0])
  );

  modport_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(3)) dut1 (
    .PCLK(clk), .PRESETn(rst), .PSELx(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one transfer from a negedge; returns at the negedge of the completing
  // cycle with the bus still selected, so the caller may chain or go idle.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input bit exp_err, input int exp_waits, input string name);
    exp_t e;
    int   cycles;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.name  = name;
    if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    @(negedge clk);
    penable[d] = 1'b1;
    cycles = 0;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (pready[d] === 1'b1) break;
    end
    if (pready[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: PREADY got %b expected 1 within 20 cycles", name, pready[d]);
    end else begin
      chk({name, "_waits"}, 32'(cycles - 1), 32'(exp_waits));
    end
  endtask

  task automatic bus_idle(input int d);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int d = 0; d < 2; d++) begin
      if (pready[d] === 1'b1) begin
        have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL unexpected_pready dut%0d: PREADY got 1 expected 0", d);
        end else begin
          if (d == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
          if (prdata[d] !== e.rdata || pslverr[d] !== e.err) begin
            errors++;
            $display("FAIL %s: PRDATA/PSLVERR got %h/%b expected %h/%b",
                     e.name, prdata[d], pslverr[d], e.rdata, e.err);
          end
        end
      end else begin
        checks++;
        if (pready[d] !== 1'b0 || prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs dut%0d: PREADY/PRDATA/PSLVERR got %b/%h/%b expected 0/00000000/0",
                   d, pready[d], prdata[d], pslverr[d]);
        end
      end
    end
  end

  initial begin
    psel    = 2'b00;
    penable = 2'b00;
    pwrite  = 2'b00;
    paddr   = '0;
    pwdata  = '0;

    repeat (2) @(negedge clk);
    chk("reset_pready0",  32'(pready[0]),  32'h0);
    chk("reset_pslverr0", 32'(pslverr[0]), 32'h0);
    chk("reset_prdata1",  prdata[1],       32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write then read of 0x04.
    xfer(0, 1'b1, 10'h004, 32'hDEADBEEF, 32'h0, 1'b0, 0, "wr_04");
    bus_idle(0);
    xfer(0, 1'b0, 10'h004, 32'h0, 32'hDEADBEEF, 1'b0, 0, "rd_04");
    bus_idle(0);
    // Byte-lane bits ignored.
    xfer(0, 1'b0, 10'h007, 32'h0, 32'hDEADBEEF, 1'b0, 0, "rd_07_lsb");
    bus_idle(0);

    // Back-to-back writes, then back-to-back reads.
    xfer(0, 1'b1, 10'h008, 32'hA5A5A5A5, 32'h0, 1'b0, 0, "wr_08");
    xfer(0, 1'b1, 10'h00C, 32'h5A5A5A5A, 32'h0, 1'b0, 0, "wr_0C");
    bus_idle(0);
    xfer(0, 1'b0, 10'h008, 32'h0, 32'hA5A5A5A5, 1'b0, 0, "rd_08");
    xfer(0, 1'b0, 10'h00C, 32'h0, 32'h5A5A5A5A, 1'b0, 0, "rd_0C");
    // Read immediately following a write to the same word.
    xfer(0, 1'b1, 10'h018, 32'hCAFEF00D, 32'h0, 1'b0, 0, "wr_18");
    xfer(0, 1'b0, 10'h018, 32'h0, 32'hCAFEF00D, 1'b0, 0, "rd_18_raw");
    bus_idle(0);

    // Last valid word and first invalid word.
    xfer(0, 1'b1, 10'h0FC, 32'h0BADC0DE, 32'h0, 1'b0, 0, "wr_FC");
    xfer(0, 1'b0, 10'h0FC, 32'h0, 32'h0BADC0DE, 1'b0, 0, "rd_FC");
    xfer(0, 1'b1, 10'h100, 32'h12345678, 32'h0, 1'b1, 0, "wr_100_err");
    xfer(0, 1'b0, 10'h100, 32'h0, 32'h0, 1'b1, 0, "rd_100_err");
    // The discarded write must not have aliased onto word 0.
    xfer(0, 1'b0, 10'h000, 32'h0, 32'h0, 1'b0, 0, "rd_00_noalias");
    bus_idle(0);

    // Abort in SETUP: write to 0x14 never happens.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 10'h014; pwdata[0] = 32'hFFFF0000;
    @(negedge clk);
    psel[0] = 1'b0;
    repeat (3) @(negedge clk);
    xfer(0, 1'b0, 10'h014, 32'h0, 32'h0, 1'b0, 0, "rd_14_abort");
    bus_idle(0);

    // Three wait states on dut1.
    xfer(1, 1'b0, 10'h000, 32'h0, 32'h0, 1'b0, 3, "ws_rd_00");
    bus_idle(1);
    xfer(1, 1'b1, 10'h020, 32'h13572468, 32'h0, 1'b0, 3, "ws_wr_20");
    bus_idle(1);
    xfer(1, 1'b0, 10'h020, 32'h0, 32'h13572468, 1'b0, 3, "ws_rd_20");
    bus_idle(1);
    // Abort during wait states: write to 0x24 dropped.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 10'h024; pwdata[1] = 32'h99999999;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (5) @(negedge clk);
    xfer(1, 1'b0, 10'h024, 32'h0, 32'h0, 1'b0, 3, "ws_rd_24_abort");
    bus_idle(1);

    // Reset during the ACCESS cycle of a write to 0x10.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 10'h010; pwdata[0] = 32'h77778888;
    @(negedge clk);
    penable[0] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_pready",  32'(pready[0]),  32'h0);
    chk("rstmid_pslverr", 32'(pslverr[0]), 32'h0);
    chk("rstmid_prdata",  prdata[0],       32'h0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xfer(0, 1'b0, 10'h010, 32'h0, 32'h0, 1'b0, 0, "rd_10_after_rst");
    xfer(0, 1'b0, 10'h004, 32'h0, 32'h0, 1'b0, 0, "rd_04_cleared");
    bus_idle(0);
    repeat (2) @(negedge clk);

    chk("sb_empty0", 32'(exp_q0.size()), 32'h0);
    chk("sb_empty1", 32'(exp_q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time got 50000 expected completion earlier");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
